fx_bus_master: RTL and testbench



---
 rtl/fx_bus_master.sv | 183 ++++++++++++++++++
 tb/tb_fx_bus_master.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fx_bus_master.sv
// fx_bus_master: host byte stream to fx register bus initiator.
// Frames: opcode, A2, A1, A0, payload. 'W' writes one byte and 'R' bursts N
// reads, where N=0 means 256. Read data is returned on the tx byte stream.
// Optional inter-byte frame timeout: define FX_MASTER_TIMEOUT_EN.
module fx_bus_master #(
  parameter int unsigned RD_LAT    = 1,
  parameter logic [23:0] TO_CYCLES = 24'd1_000_000
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_vld,
  output logic        rx_rdy,
  output logic [7:0]  tx_data,
  output logic        tx_vld,
  input  logic        tx_rdy,
  output logic [21:0] fx_waddr,
  output logic        fx_wr,
  output logic [7:0]  fx_data,
  output logic [21:0] fx_raddr,
  output logic        fx_rd,
  input  logic [7:0]  fx_q,
  output logic        busy,
  output logic [7:0]  err_cnt
);

  localparam logic [7:0]  OP_W = 8'h57;
  localparam logic [7:0]  OP_R = 8'h52;
  localparam int unsigned WW   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_A2, S_A1, S_A0, S_PAY, S_WR, S_RD_ISSUE, S_RD_WAIT, S_RD_SEND
  } state_t;

  state_t          state, state_nxt;
  logic            rx_acc, tx_acc, bad_op, timeout, wait_last, op_wr;
  logic [21:0]     addr;
  logic [8:0]      rem;
  logic [WW-1:0]   wait_cnt;

  assign rx_acc    = rx_vld & rx_rdy;
  assign tx_acc    = tx_vld & tx_rdy;
  assign wait_last = (wait_cnt == WW'(RD_LAT - 1));
  assign busy      = (state != S_IDLE);

`ifdef FX_MASTER_TIMEOUT_EN
  logic [23:0] to_cnt;
  logic        in_frame;
  assign in_frame = (state == S_A2) || (state == S_A1) || (state == S_A0) || (state == S_PAY);
  assign timeout  = in_frame && !rx_vld && (to_cnt == TO_CYCLES - 24'd1);

  // Inter-byte timer: runs only while a frame header/payload is pending
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (!in_frame || rx_vld || timeout) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 24'd1;
    end
  end
`else
  logic unused_to_cycles;
  assign unused_to_cycles = ^TO_CYCLES;
  assign timeout          = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake/strobe outputs; everything is forced off in reset
  always_comb begin
    state_nxt = state;
    rx_rdy    = 1'b0;
    fx_wr     = 1'b0;
    fx_rd     = 1'b0;
    tx_vld    = 1'b0;
    bad_op    = 1'b0;
    case (state)
      S_IDLE: begin
        rx_rdy = 1'b1;
        if (rx_vld) begin
          if (rx_data == OP_W || rx_data == OP_R) state_nxt = S_A2;
          else                                    bad_op    = 1'b1;
        end
      end
      S_A2: begin
        rx_rdy = 1'b1;
        if (rx_vld) state_nxt = S_A1;
      end
      S_A1: begin
        rx_rdy = 1'b1;
        if (rx_vld) state_nxt = S_A0;
      end
      S_A0: begin
        rx_rdy = 1'b1;
        if (rx_vld) state_nxt = S_PAY;
      end
      S_PAY: begin
        rx_rdy = 1'b1;
        if (rx_vld) state_nxt = op_wr ? S_WR : S_RD_ISSUE;
      end
      S_WR: begin
        fx_wr     = 1'b1;
        state_nxt = S_IDLE;
      end
      S_RD_ISSUE: begin
        fx_rd     = 1'b1;
        state_nxt = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (wait_last) state_nxt = S_RD_SEND;
      end
      S_RD_SEND: begin
        tx_vld = 1'b1;
        if (tx_rdy) state_nxt = (rem == 9'd1) ? S_IDLE : S_RD_ISSUE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (timeout) state_nxt = S_IDLE;
    if (rst) begin
      rx_rdy    = 1'b0;
      fx_wr     = 1'b0;
      fx_rd     = 1'b0;
      tx_vld    = 1'b0;
      bad_op    = 1'b0;
      state_nxt = S_IDLE;
    end
  end

  // Frame capture, bus address/data, read sequencing and error counter
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      op_wr    <= 1'b0;
      addr     <= '0;
      rem      <= '0;
      wait_cnt <= '0;
      fx_waddr <= '0;
      fx_data  <= '0;
      fx_raddr <= '0;
      tx_data  <= '0;
      err_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE:  if (rx_acc) op_wr <= (rx_data == OP_W);
        S_A2:    if (rx_acc) addr[21:16] <= rx_data[5:0];
        S_A1:    if (rx_acc) addr[15:8]  <= rx_data;
        S_A0:    if (rx_acc) addr[7:0]   <= rx_data;
        S_PAY: begin
          if (rx_acc) begin
            if (op_wr) begin
              fx_waddr <= addr;
              fx_data  <= rx_data;
            end else begin
              fx_raddr <= addr;
              rem      <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
            end
          end
        end
        S_RD_ISSUE: wait_cnt <= '0;
        S_RD_WAIT: begin
          wait_cnt <= wait_cnt + WW'(1);
          if (wait_last) tx_data <= fx_q;
        end
        S_RD_SEND: begin
          if (tx_acc) begin
            rem            <= rem - 9'd1;
            fx_raddr[15:0] <= fx_raddr[15:0] + 16'd1;
          end
        end
        default: ;
      endcase
      if ((bad_op || timeout) && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_fx_bus_master.sv
// Self-checking bench for fx_bus_master: frame-level model with expectation
// queues, a registered slave model, and a per-cycle compare process.
module tb_fx_bus_master;

`ifdef FX_MASTER_TIMEOUT_EN
  localparam logic [23:0] TB_TO = 24'd16;
`else
  localparam logic [23:0] TB_TO = 24'd1_000_000;
`endif
  localparam int unsigned TB_LAT = 1;

  logic        clk_sys = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_vld = 1'b0;
  logic        rx_rdy;
  logic [7:0]  tx_data;
  logic        tx_vld;
  logic        tx_rdy = 1'b1;
  logic [21:0] fx_waddr;
  logic        fx_wr;
  logic [7:0]  fx_data;
  logic [21:0] fx_raddr;
  logic        fx_rd;
  logic [7:0]  fx_q = 8'h00;
  logic        busy;
  logic [7:0]  err_cnt;

  fx_bus_master #(.RD_LAT(TB_LAT), .TO_CYCLES(TB_TO)) dut (
    .clk_sys(clk_sys), .rst(rst),
    .rx_data(rx_data), .rx_vld(rx_vld), .rx_rdy(rx_rdy),
    .tx_data(tx_data), .tx_vld(tx_vld), .tx_rdy(tx_rdy),
    .fx_waddr(fx_waddr), .fx_wr(fx_wr), .fx_data(fx_data),
    .fx_raddr(fx_raddr), .fx_rd(fx_rd), .fx_q(fx_q),
    .busy(busy), .err_cnt(err_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave contents: a fixed function of the address
  function automatic logic [7:0] slave_f(input logic [21:0] a);
    return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ 8'h2B;
  endfunction

  // Registered slave: data appears one cycle after the read strobe, zero otherwise
  always @(posedge clk_sys) fx_q <= fx_rd ? slave_f(fx_raddr) : 8'h00;

  // Model state
  logic [29:0] exp_wr[$];
  logic [21:0] exp_rd[$];
  logic [7:0]  exp_tx[$];
  logic [21:0] rd_log[$];
  int unsigned model_err = 0;
  int unsigned rd_seen = 0;
  bit          stall_en = 1'b0;
  int unsigned stall_ctr = 0;

  // Compare process
  bit          rd_due = 1'b0;
  bit          tx_held = 1'b0;
  logic [7:0]  held_data = 8'h00;
  logic [29:0] ew;
  logic [21:0] er;
  logic [7:0]  et;
  always @(negedge clk_sys) begin
    if (rst) begin
      rd_due  = 1'b0;
      tx_held = 1'b0;
    end else begin
      if (fx_wr && fx_rd) chk("wr_rd_overlap", 32'd1, 32'd0);
      if (rd_due) chk("burst_rd_next", {31'd0, fx_rd}, 32'd1);
      rd_due = 1'b0;
      if (fx_wr) begin
        if (exp_wr.size() == 0) chk("unexpected_wr", 32'd1, 32'd0);
        else begin
          ew = exp_wr.pop_front();
          chk("wr_addr", {10'd0, fx_waddr}, {10'd0, ew[29:8]});
          chk("wr_data", {24'd0, fx_data}, {24'd0, ew[7:0]});
        end
      end
      if (fx_rd) begin
        rd_seen++;
        rd_log.push_back(fx_raddr);
        if (exp_rd.size() == 0) chk("unexpected_rd", 32'd1, 32'd0);
        else begin
          er = exp_rd.pop_front();
          chk("rd_addr", {10'd0, fx_raddr}, {10'd0, er});
        end
      end
      if (tx_held) begin
        chk("tx_vld_hold", {31'd0, tx_vld}, 32'd1);
        chk("tx_data_hold", {24'd0, tx_data}, {24'd0, held_data});
      end
      if (tx_vld && tx_rdy) begin
        if (exp_tx.size() == 0) chk("unexpected_tx", 32'd1, 32'd0);
        else begin
          et = exp_tx.pop_front();
          chk("tx_data", {24'd0, tx_data}, {24'd0, et});
          if (exp_tx.size() != 0) rd_due = 1'b1;
        end
      end
      tx_held   = tx_vld && !tx_rdy;
      held_data = tx_data;
      chk("err_cnt", {24'd0, err_cnt}, model_err);
    end
  end

  // Host tx side: tied ready, or stall 5 cycles per byte when stall_en
  initial forever begin
    @(posedge clk_sys); #1;
    if (!stall_en) tx_rdy = 1'b1;
    else if (tx_rdy) begin
      tx_rdy    = 1'b0;
      stall_ctr = 0;
    end else if (tx_vld) begin
      stall_ctr++;
      if (stall_ctr >= 5) tx_rdy = 1'b1;
    end
  end

  // Present one byte; returns 1 ns after the accepting edge
  task automatic send_byte(input logic [7:0] b);
    int unsigned n = 0;
    bit acc = 1'b0;
    rx_data = b;
    rx_vld  = 1'b1;
    do begin
      @(negedge clk_sys); acc = rx_rdy;
      @(posedge clk_sys); #1;
      n++;
    end while (!acc && n < 200);
    rx_vld = 1'b0;
    if (!acc) chk("rx_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic bump_err();
    if (model_err < 255) model_err++;
  endtask

  task automatic wait_done();
    int unsigned n = 0;
    while ((busy || exp_tx.size() != 0 || exp_rd.size() != 0 || exp_wr.size() != 0) && n < 3000) begin
      @(posedge clk_sys); #1;
      n++;
    end
    chk("done_timeout", {31'd0, (n < 3000)}, 32'd1);
  endtask

  task automatic do_write(input logic [7:0] a2, input logic [7:0] a1, input logic [7:0] a0,
                          input logic [7:0] d);
    exp_wr.push_back({a2[5:0], a1, a0, d});
    send_byte(8'h57); send_byte(a2); send_byte(a1); send_byte(a0); send_byte(d);
    chk("wr_strobe", {31'd0, fx_wr}, 32'd1);
    chk("wr_rx_rdy_low", {31'd0, rx_rdy}, 32'd0);
    chk("wr_no_tx", {31'd0, tx_vld}, 32'd0);
    @(posedge clk_sys); #1;
    chk("wr_single", {31'd0, fx_wr}, 32'd0);
    wait_done();
  endtask

  task automatic do_read(input logic [7:0] a2, input logic [7:0] a1, input logic [7:0] a0,
                         input logic [7:0] n);
    int unsigned cnt;
    logic [15:0] off;
    logic [21:0] a;
    cnt = (n == 8'h00) ? 256 : int'(n);
    for (int unsigned i = 0; i < cnt; i++) begin
      off = {a1, a0} + 16'(i);
      a   = {a2[5:0], off};
      exp_rd.push_back(a);
      exp_tx.push_back(slave_f(a));
    end
    rd_log.delete();
    send_byte(8'h52); send_byte(a2); send_byte(a1); send_byte(a0); send_byte(n);
    chk("rd_strobe", {31'd0, fx_rd}, 32'd1);
    chk("rd_rx_rdy_low", {31'd0, rx_rdy}, 32'd0);
    repeat (TB_LAT) begin @(posedge clk_sys); #1; end
    chk("rd_tx_early", {31'd0, tx_vld}, 32'd0);
    @(posedge clk_sys); #1;
    chk("rd_tx_rise", {31'd0, tx_vld}, 32'd1);
    wait_done();
  endtask

  int unsigned snap;

  initial begin
    // Reset state, checked while reset is still asserted
    repeat (3) begin @(posedge clk_sys); #1; end
    chk("rst_rx_rdy", {31'd0, rx_rdy}, 32'd0);
    chk("rst_fx_wr", {31'd0, fx_wr}, 32'd0);
    chk("rst_fx_rd", {31'd0, fx_rd}, 32'd0);
    chk("rst_waddr", {10'd0, fx_waddr}, 32'd0);
    chk("rst_raddr", {10'd0, fx_raddr}, 32'd0);
    chk("rst_data", {24'd0, fx_data}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_tx_vld", {31'd0, tx_vld}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {24'd0, err_cnt}, 32'd0);
    rst = 1'b0;
    @(posedge clk_sys); #1;
    chk("idle_rx_rdy", {31'd0, rx_rdy}, 32'd1);

    // Bad opcode is dropped and counted
    send_byte(8'h33); bump_err();
    chk("bad_op_err", {24'd0, err_cnt}, 32'd1);
    chk("bad_op_idle", {31'd0, busy}, 32'd0);

    // Write from the test plan, with literal pins
    exp_wr.push_back({22'h010021, 8'h0A});
    send_byte(8'h57); send_byte(8'h01); send_byte(8'h00); send_byte(8'h21); send_byte(8'h0A);
    chk("wr_lit_strobe", {31'd0, fx_wr}, 32'd1);
    chk("wr_lit_addr", {10'd0, fx_waddr}, 32'h010021);
    chk("wr_lit_data", {24'd0, fx_data}, 32'h0A);
    @(posedge clk_sys); #1;
    chk("wr_lit_single", {31'd0, fx_wr}, 32'd0);
    wait_done();

    // A2[7:6] ignored
    do_write(8'hC3, 8'h12, 8'h34, 8'hE7);

    // Single read from the test plan
    exp_rd.push_back(22'h010020); exp_tx.push_back(8'h0A);
    send_byte(8'h52); send_byte(8'h01); send_byte(8'h00); send_byte(8'h20); send_byte(8'h01);
    chk("rd_lit_strobe", {31'd0, fx_rd}, 32'd1);
    chk("rd_lit_addr", {10'd0, fx_raddr}, 32'h010020);
    @(posedge clk_sys); #1;
    @(posedge clk_sys); #1;
    chk("rd_lit_vld", {31'd0, tx_vld}, 32'd1);
    chk("rd_lit_data", {24'd0, tx_data}, 32'h0A);
    wait_done();

    // Burst with offset wrap, tied ready then stalled
    do_read(8'h01, 8'hFF, 8'hFF, 8'h03);
    chk("wrap_cnt", rd_log.size(), 32'd3);
    chk("wrap_a0", {10'd0, rd_log[0]}, 32'h01FFFF);
    chk("wrap_a1", {10'd0, rd_log[1]}, 32'h010000);
    chk("wrap_a2", {10'd0, rd_log[2]}, 32'h010001);
    stall_en = 1'b1;
    rd_log.delete();
    for (int unsigned i = 0; i < 3; i++) begin
      er = 22'h01FFFF + 22'(i);
      exp_rd.push_back({6'h01, er[15:0]});
      exp_tx.push_back(slave_f({6'h01, er[15:0]}));
    end
    send_byte(8'h52); send_byte(8'h01); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h03);
    wait_done();
    chk("stall_rd_cnt", rd_log.size(), 32'd3);
    stall_en = 1'b0;
    @(posedge clk_sys); #1;

    // N=0 means 256 reads, wrapping within device 3
    do_read(8'h03, 8'hFF, 8'hF0, 8'h00);
    chk("n0_cnt", rd_log.size(), 32'd256);
    chk("n0_wrap", {10'd0, rd_log[16]}, 32'h030000);

    // Partial frame: abort on timeout, or wait indefinitely without it
    exp_wr.push_back({22'h010080, 8'h5A});
    send_byte(8'h57); send_byte(8'h01);
`ifdef FX_MASTER_TIMEOUT_EN
    repeat (15) begin @(posedge clk_sys); #1; end
    chk("to_not_yet", {31'd0, busy}, 32'd1);
    @(posedge clk_sys); #1;
    bump_err();
    chk("to_abort_idle", {31'd0, busy}, 32'd0);
    chk("to_err", {24'd0, err_cnt}, 32'd2);
    send_byte(8'h57); send_byte(8'h01);
`else
    repeat (40) begin @(posedge clk_sys); #1; end
    chk("no_to_busy", {31'd0, busy}, 32'd1);
    chk("no_to_err", {24'd0, err_cnt}, 32'd1);
`endif
    send_byte(8'h00); send_byte(8'h80); send_byte(8'h5A);
    chk("late_wr_strobe", {31'd0, fx_wr}, 32'd1);
    chk("late_wr_addr", {10'd0, fx_waddr}, 32'h010080);
    chk("late_wr_data", {24'd0, fx_data}, 32'h5A);
    wait_done();

    // err_cnt saturation
    for (int unsigned i = 0; i < 260; i++) begin
      send_byte(8'hA5); bump_err();
    end
    chk("err_sat", {24'd0, err_cnt}, 32'hFF);

    // Reset during RD_WAIT of a 4-read burst
    for (int unsigned i = 0; i < 4; i++) begin
      exp_rd.push_back(22'h011000 + 22'(i));
      exp_tx.push_back(slave_f(22'h011000 + 22'(i)));
    end
    send_byte(8'h52); send_byte(8'h01); send_byte(8'h10); send_byte(8'h00); send_byte(8'h04);
    chk("rst_burst_rd", {31'd0, fx_rd}, 32'd1);
    @(posedge clk_sys); #1;
    rst = 1'b1;
    @(posedge clk_sys); #1;
    exp_rd.delete(); exp_tx.delete(); model_err = 0;
    chk("midrst_tx_vld", {31'd0, tx_vld}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_err", {24'd0, err_cnt}, 32'd0);
    rst = 1'b0;
    snap = rd_seen;
    repeat (20) begin @(posedge clk_sys); #1; end
    chk("midrst_no_rd", rd_seen, snap);
    chk("midrst_idle", {31'd0, busy}, 32'd0);
    chk("midrst_tx_off", {31'd0, tx_vld}, 32'd0);

    // Normal operation after reset
    do_write(8'h01, 8'h00, 8'h21, 8'h0A);
    chk("final_queues", exp_wr.size() + exp_rd.size() + exp_tx.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
